// File: rtl/beat_packer.sv
// rtl/beat_packer.sv - packs up to PACK_COUNT narrow beats into one wide registered word
// Optional build macro: PACKER_PARITY_EN adds the per-lane parity output dn_par.
module beat_packer #(
   parameter int DATA_WIDTH = 7,
   parameter int PACK_COUNT = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [DATA_WIDTH-1:0]            up_bus,
   input  logic                             up_val,
   input  logic                             up_last,
   output logic                             up_rdy,
   output logic [DATA_WIDTH*PACK_COUNT-1:0] dn_bus,
   output logic [PACK_COUNT-1:0]            dn_keep,
   output logic                             dn_val,
`ifdef PACKER_PARITY_EN
   output logic [PACK_COUNT-1:0]            dn_par,
`endif
   input  logic                             dn_rdy
);

   localparam int CNT_W = (PACK_COUNT > 1) ? $clog2(PACK_COUNT) : 1;
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(PACK_COUNT - 1);

   typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

   state_t                            state_q, state_d;
   logic [CNT_W-1:0]                  cnt_q, cnt_d;
   logic [DATA_WIDTH*PACK_COUNT-1:0]  bus_q, bus_d;
   logic [PACK_COUNT-1:0]             keep_q, keep_d;
   logic [PACK_COUNT-1:0]             par_q, par_d;
   logic                              accept;
   logic                              beat_par;

   // Ready is combinational on dn_rdy so a delivering word can be refilled in the same cycle.
   always_comb begin
      up_rdy   = rst && ((state_q == FILL) || dn_rdy);
      accept   = up_val && up_rdy;
      beat_par = ^up_bus;
   end

   // Next-state logic: lane writes while filling, deliver/refill while full.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bus_d   = bus_q;
      keep_d  = keep_q;
      par_d   = par_q;
      case (state_q)
         FILL: begin
            if (accept) begin
               for (int i = 0; i < PACK_COUNT; i++) begin
                  if (cnt_q == CNT_W'(i)) begin
                     bus_d[i*DATA_WIDTH +: DATA_WIDTH] = up_bus;
                     keep_d[i] = 1'b1;
                     par_d[i]  = beat_par;
                  end
               end
               if ((cnt_q == LAST_LANE) || up_last) begin
                  state_d = FULL;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         FULL: begin
            if (dn_rdy) begin
               if (accept) begin
                  // Old word leaves; the new beat opens the next packet in lane 0.
                  bus_d                = '0;
                  bus_d[DATA_WIDTH-1:0] = up_bus;
                  keep_d               = PACK_COUNT'(1);
                  par_d                = '0;
                  par_d[0]             = beat_par;
                  if (up_last) begin
                     state_d = FULL;
                     cnt_d   = '0;
                  end else begin
                     state_d = FILL;
                     cnt_d   = CNT_W'(1);
                  end
               end else begin
                  bus_d   = '0;
                  keep_d  = '0;
                  par_d   = '0;
                  state_d = FILL;
                  cnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = FILL;
            cnt_d   = '0;
         end
      endcase
   end

   // State and output word registers; reset discards any partial packet.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= FILL;
         cnt_q   <= '0;
         bus_q   <= '0;
         keep_q  <= '0;
         par_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bus_q   <= bus_d;
         keep_q  <= keep_d;
         par_q   <= par_d;
      end
   end

   // Output word is valid exactly while the packer holds a closed packet.
   always_comb begin
      dn_val  = (state_q == FULL);
      dn_bus  = bus_q;
      dn_keep = keep_q;
   end

`ifdef PACKER_PARITY_EN
   // Per-lane parity travels with the lane data.
   always_comb begin
      dn_par = par_q;
   end
`else
   logic unused_par;
   // Parity bits are not exported in this build.
   always_comb begin
      unused_par = ^par_q;
   end
`endif

endmodule

// File: tb/tb_beat_packer.sv
// tb/tb_beat_packer.sv - self-checking bench for beat_packer
module tb_beat_packer;

   localparam int DW = 7;
   localparam int PC = 4;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic [DW-1:0]      up_bus = '0;
   logic               up_val = 1'b0;
   logic               up_last = 1'b0;
   logic               up_rdy;
   logic [DW*PC-1:0]   dn_bus;
   logic [PC-1:0]      dn_keep;
   logic               dn_val;
   logic               dn_rdy = 1'b1;
`ifdef PACKER_PARITY_EN
   logic [PC-1:0]      dn_par;
`endif

   int n_chk = 0;
   int n_bad = 0;

   beat_packer #(.DATA_WIDTH(DW), .PACK_COUNT(PC)) dut (
      .clk(clk),
      .rst(rst),
      .up_bus(up_bus),
      .up_val(up_val),
      .up_last(up_last),
      .up_rdy(up_rdy),
      .dn_bus(dn_bus),
      .dn_keep(dn_keep),
      .dn_val(dn_val),
`ifdef PACKER_PARITY_EN
      .dn_par(dn_par),
`endif
      .dn_rdy(dn_rdy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference model: the open packet is a queue of beats; a closed packet waits in a one-word slot.
   logic [DW-1:0] cur[$];
   logic [DW-1:0] outw[$];
   bit            out_v = 1'b0;
   int            cycle = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur.delete();
         outw.delete();
         out_v = 1'b0;
      end else begin
         bit acc;
         acc = up_val && (!out_v || dn_rdy);
         if (out_v && dn_rdy) begin
            out_v = 1'b0;
            outw.delete();
         end
         if (acc) begin
            cur.push_back(up_bus);
            if (cur.size() == PC || up_last) begin
               outw = cur;
               cur.delete();
               out_v = 1'b1;
            end
         end
         cycle++;
      end
   end

   // Deliveries observed on the DUT side, for spacing checks.
   int            dcyc[$];
   logic [PC-1:0] dkeep[$];

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      logic [DW*PC-1:0] eb;
      logic [PC-1:0]    ek;
      logic [PC-1:0]    ep;
      eb = '0;
      ek = '0;
      ep = '0;
      if (out_v) begin
         foreach (outw[i]) begin
            eb[i*DW +: DW] = outw[i];
            ek[i] = 1'b1;
            ep[i] = ^outw[i];
         end
      end else begin
         foreach (cur[i]) begin
            eb[i*DW +: DW] = cur[i];
            ek[i] = 1'b1;
            ep[i] = ^cur[i];
         end
      end
      chk("cyc_dn_val", 64'(dn_val), 64'(out_v));
      chk("cyc_dn_bus", 64'(dn_bus), 64'(eb));
      chk("cyc_dn_keep", 64'(dn_keep), 64'(ek));
      chk("cyc_up_rdy", 64'(up_rdy), 64'(rst && (!out_v || dn_rdy)));
`ifdef PACKER_PARITY_EN
      chk("cyc_dn_par", 64'(dn_par), 64'(ep));
`else
      if (ep != ep) n_bad++;
`endif
      if (dn_val && dn_rdy) begin
         dcyc.push_back(cycle);
         dkeep.push_back(dn_keep);
      end
   end

   task automatic beat(input logic [DW-1:0] b, input logic l);
      up_val  = 1'b1;
      up_bus  = b;
      up_last = l;
      cyc();
   endtask

   initial begin
      int base;
      int deasserts;
      logic [DW*PC-1:0] held;

      // Reset held low with a beat offered.
      rst = 1'b0; up_val = 1'b1; up_bus = 7'h55; dn_rdy = 1'b1;
      repeat (3) cyc();
      chk("rst_dn_val", 64'(dn_val), 64'd0);
      chk("rst_dn_keep", 64'(dn_keep), 64'd0);
      chk("rst_dn_bus", 64'(dn_bus), 64'd0);
      chk("rst_up_rdy", 64'(up_rdy), 64'd0);
      up_val = 1'b0;
      rst = 1'b1;
      #1;
      chk("rel_up_rdy", 64'(up_rdy), 64'd1);
      repeat (3) cyc();
      chk("rel_no_pkt", 64'(dcyc.size()), 64'd0);

      // Full four-beat packet.
      beat(7'h11, 1'b0); beat(7'h22, 1'b0); beat(7'h33, 1'b0); beat(7'h44, 1'b0);
      up_val = 1'b0;
      chk("full_val", 64'(dn_val), 64'd1);
      chk("full_bus", 64'(dn_bus), 64'h88CD111);
      chk("full_keep", 64'(dn_keep), 64'hF);
      cyc();
      chk("full_one_cycle", 64'(dn_val), 64'd0);
      chk("full_delivered", 64'(dcyc.size()), 64'd1);

      // Early close on the second beat.
      beat(7'h05, 1'b0); beat(7'h7F, 1'b1);
      up_val = 1'b0; up_last = 1'b0;
      chk("early_val", 64'(dn_val), 64'd1);
      chk("early_bus", 64'(dn_bus), 64'h0003F85);
      chk("early_keep", 64'(dn_keep), 64'h3);
`ifdef PACKER_PARITY_EN
      chk("early_par", 64'(dn_par), 64'h2);
`endif
      cyc();

      // Backpressure with a beat waiting.
      beat(7'h11, 1'b0); beat(7'h22, 1'b0); beat(7'h33, 1'b0); beat(7'h44, 1'b0);
      dn_rdy = 1'b0; up_val = 1'b1; up_bus = 7'h01; up_last = 1'b0;
      held = dn_bus;
      chk("bp_bus_start", 64'(held), 64'h88CD111);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_up_rdy", 64'(up_rdy), 64'd0);
         cyc();
         chk("bp_bus_stable", 64'(dn_bus), 64'(held));
         chk("bp_keep_stable", 64'(dn_keep), 64'hF);
         chk("bp_val_stable", 64'(dn_val), 64'd1);
      end
      dn_rdy = 1'b1;
      #1;
      chk("bp_release_rdy", 64'(up_rdy), 64'd1);
      cyc();
      chk("bp_after_val", 64'(dn_val), 64'd0);
      chk("bp_after_keep", 64'(dn_keep), 64'h1);
      chk("bp_after_bus", 64'(dn_bus), 64'h0000001);
      beat(7'h02, 1'b1);
      up_val = 1'b0; up_last = 1'b0;
      chk("bp_close_bus", 64'(dn_bus), 64'h0000101);
      cyc();

      // Streaming: twelve back-to-back beats.
      base = dcyc.size();
      deasserts = 0;
      for (int i = 0; i < 12; i++) begin
         up_val = 1'b1; up_bus = DW'(i); up_last = 1'b0;
         #1;
         if (!up_rdy) deasserts++;
         cyc();
      end
      up_val = 1'b0;
      repeat (2) cyc();
      chk("stream_rdy_held", 64'(deasserts), 64'd0);
      chk("stream_pkts", 64'(dcyc.size() - base), 64'd3);
      if (dcyc.size() - base == 3) begin
         for (int i = 0; i < 3; i++) chk("stream_keep", 64'(dkeep[base+i]), 64'hF);
         chk("stream_gap1", 64'(dcyc[base+1] - dcyc[base]), 64'd4);
         chk("stream_gap2", 64'(dcyc[base+2] - dcyc[base+1]), 64'd4);
      end

      // Reset in the middle of a packet.
      beat(7'h21, 1'b0); beat(7'h22, 1'b0);
      up_val = 1'b0;
      rst = 1'b0;
      #1;
      chk("mid_rst_bus", 64'(dn_bus), 64'd0);
      chk("mid_rst_keep", 64'(dn_keep), 64'd0);
      cyc();
      rst = 1'b1;
      beat(7'h41, 1'b0); beat(7'h42, 1'b0); beat(7'h43, 1'b0); beat(7'h44, 1'b0);
      up_val = 1'b0;
      chk("mid_val", 64'(dn_val), 64'd1);
      chk("mid_bus", 64'(dn_bus), 64'h890E141);
      chk("mid_keep", 64'(dn_keep), 64'hF);
      repeat (2) cyc();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
